// File: rtl/sdp_ram_arbiter.sv
// Round-robin write/read arbiter in front of a simple dual-port RAM, with an in-order tag FIFO
// that routes read returns back to their issuing client. Optional macro: SDP_ARB_COLLISION_STALL_EN.
module sdp_ram_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_wr_valid,
  output logic [NUM_REQ-1:0]            req_wr_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data,
  input  logic [NUM_REQ-1:0]            req_rd_valid,
  output logic [NUM_REQ-1:0]            req_rd_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd_addr,
  output logic [DATA_WIDTH-1:0]         rsp_rd_data,
  output logic [NUM_REQ-1:0]            rsp_rd_valid,
  output logic                          ram_wr_en,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
  output logic [DATA_WIDTH-1:0]         ram_wr_data,
  output logic                          ram_rd_en,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data,
  input  logic                          ram_rd_data_valid,
  output logic                          err_underflow
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int TAG_AW = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = TAG_AW + 1;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [TAG_AW-1:0] tag_ptr_t;

  // Returns {found, index} of the first valid client at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] valid, input idx_t ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (valid[idx]) res = {1'b1, idx[IDX_W-1:0]};
    end
    return res;
  endfunction

  function automatic idx_t rr_next(input idx_t g);
    return (g == idx_t'(NUM_REQ - 1)) ? '0 : g + idx_t'(1);
  endfunction

  idx_t                  wr_ptr, rd_ptr;
  idx_t                  wr_gnt, rd_gnt;
  logic                  wr_any, rd_any;
  logic                  wr_accept, rd_accept, rd_stall;
  logic [ADDR_WIDTH-1:0] wr_addr_sel, rd_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;

  tag_ptr_t              tag_wr_idx, tag_rd_idx;
  logic [CNT_W-1:0]      tag_cnt;
  logic                  tag_full, pop, underflow_evt;
  idx_t                  tag_mem [MAX_OUTSTANDING];

  assign {wr_any, wr_gnt} = rr_pick(req_wr_valid, wr_ptr);
  assign {rd_any, rd_gnt} = rr_pick(req_rd_valid, rd_ptr);

  assign wr_addr_sel = req_wr_addr[int'(wr_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
  assign wr_data_sel = req_wr_data[int'(wr_gnt)*DATA_WIDTH +: DATA_WIDTH];
  assign rd_addr_sel = req_rd_addr[int'(rd_gnt)*ADDR_WIDTH +: ADDR_WIDTH];

  // Full is judged on the count at the start of the cycle, so a same-cycle return cannot free a slot.
  assign tag_full      = (tag_cnt == CNT_W'(MAX_OUTSTANDING));
  assign pop           = ram_rd_data_valid && (tag_cnt != '0);
  assign underflow_evt = ram_rd_data_valid && (tag_cnt == '0);

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    rd_stall = 1'b0;
`ifdef SDP_ARB_COLLISION_STALL_EN
    // Hold the read back one cycle so the colliding write reaches the RAM first.
    if (wr_any && rd_any && (wr_addr_sel == rd_addr_sel)) rd_stall = 1'b1;
`endif
    wr_accept    = wr_any && !rst;
    rd_accept    = rd_any && !tag_full && !rd_stall && !rst;
    req_wr_ready = wr_accept ? (NUM_REQ'(1) << wr_gnt) : '0;
    req_rd_ready = rd_accept ? (NUM_REQ'(1) << rd_gnt) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      ram_wr_en <= wr_accept;
      if (wr_accept) begin
        ram_wr_addr <= wr_addr_sel;
        ram_wr_data <= wr_data_sel;
        wr_ptr      <= rr_next(wr_gnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
    end else begin
      ram_rd_en <= rd_accept;
      if (rd_accept) begin
        ram_rd_addr <= rd_addr_sel;
        rd_ptr      <= rr_next(rd_gnt);
      end
    end
  end

  // NOTE: tag storage has no reset; only entries below tag_cnt are ever read, and those were written first.
  always_ff @(posedge clk) begin
    if (rd_accept) tag_mem[tag_wr_idx] <= rd_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_idx <= '0;
      tag_rd_idx <= '0;
      tag_cnt    <= '0;
    end else begin
      if (rd_accept) tag_wr_idx <= tag_wr_idx + tag_ptr_t'(1);
      if (pop)       tag_rd_idx <= tag_rd_idx + tag_ptr_t'(1);
      case ({rd_accept, pop})
        2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rd_valid  <= '0;
      rsp_rd_data   <= '0;
      err_underflow <= 1'b0;
    end else begin
      rsp_rd_valid <= pop ? (NUM_REQ'(1) << tag_mem[tag_rd_idx]) : '0;
      if (pop)           rsp_rd_data   <= ram_rd_data;
      if (underflow_evt) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// Self-checking bench for sdp_ram_arbiter: table-driven grant vectors, directed corner sequences,
// and a randomized run scored against a transaction-level model. Includes a 1-cycle-latency RAM model.
module tb_sdp_ram_arbiter;

  localparam int N    = 2;
  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_wr_valid, req_wr_ready, req_rd_valid, req_rd_ready, rsp_rd_valid;
  logic [N*AW-1:0] req_wr_addr, req_rd_addr;
  logic [N*DW-1:0] req_wr_data;
  logic [DW-1:0]   rsp_rd_data, ram_wr_data, ram_rd_data;
  logic [AW-1:0]   ram_wr_addr, ram_rd_addr;
  logic            ram_wr_en, ram_rd_en, ram_rd_data_valid, err_underflow;

  logic ret_en, ret_one, inj;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rsp_cnt = 0;

  sdp_ram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready),
    .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data),
    .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready), .req_rd_addr(req_rd_addr),
    .rsp_rd_data(rsp_rd_data), .rsp_rd_valid(rsp_rd_valid),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .ram_rd_data_valid(ram_rd_data_valid),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // RAM model: reads sample before the same-edge write; returns can be held back to build backpressure.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pend [$];
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      ram_rd_data_valid <= 1'b0;
      ram_rd_data       <= '0;
    end else begin
      if (ram_rd_en) pend.push_back(mem[ram_rd_addr]);
      if (inj) begin
        ram_rd_data_valid <= 1'b1;
        ram_rd_data       <= 8'hEE;
      end else if ((ret_en || ret_one) && pend.size() > 0) begin
        ram_rd_data_valid <= 1'b1;
        ram_rd_data       <= pend.pop_front();
      end else begin
        ram_rd_data_valid <= 1'b0;
      end
      if (ram_wr_en) mem[ram_wr_addr] = ram_wr_data;
    end
  end

  always @(negedge clk) rsp_cnt += $countones(rsp_rd_valid);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_wr_valid = '0; req_rd_valid = '0;
    req_wr_addr  = '0; req_wr_data  = '0; req_rd_addr = '0;
    ret_en = 1'b1; ret_one = 1'b0; inj = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    clear_inputs();
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr_addr[c*AW +: AW] = a;
    req_wr_data[c*DW +: DW] = d;
  endtask

  task automatic set_rd(input int c, input logic [AW-1:0] a);
    req_rd_addr[c*AW +: AW] = a;
  endtask

  // Reference arbitration rule: first valid client scanning upward from p, modulo N.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  typedef struct packed {
    logic [1:0] wv, rv, wr_rdy, rd_rdy;
    logic       wr_en;
    logic [7:0] wr_addr, wr_data;
  } vec_t;
  vec_t tbl [11];

  typedef struct {
    int            c;
    logic [DW-1:0] d;
  } tag_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tag_t          tq [$];
    tag_t          hd;
    logic [DW-1:0] mdl_mem [256];
    int            wp, rp, ew, er, base, got;
    logic          rd_ok, popping, e_wen, e_ren, coll;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [DW-1:0] e_wdata, e_rsp_d;
    logic [N-1:0]  e_rsp_v;

    //           wv     rv     wr_rdy rd_rdy en    addr   data
    tbl[0]  = '{2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{2'b11, 2'b00, 2'b10, 2'b00, 1'b1, 8'h40, 8'hA0};
    tbl[2]  = '{2'b11, 2'b00, 2'b01, 2'b00, 1'b1, 8'h41, 8'hA1};
    tbl[3]  = '{2'b11, 2'b00, 2'b10, 2'b00, 1'b1, 8'h40, 8'hA0};
    tbl[4]  = '{2'b11, 2'b00, 2'b01, 2'b00, 1'b1, 8'h41, 8'hA1};
    tbl[5]  = '{2'b11, 2'b00, 2'b10, 2'b00, 1'b1, 8'h40, 8'hA0};
    tbl[6]  = '{2'b10, 2'b10, 2'b10, 2'b10, 1'b1, 8'h41, 8'hA1};
    tbl[7]  = '{2'b01, 2'b11, 2'b01, 2'b01, 1'b1, 8'h41, 8'hA1};
    tbl[8]  = '{2'b00, 2'b11, 2'b00, 2'b10, 1'b1, 8'h40, 8'hA0};
    tbl[9]  = '{2'b11, 2'b01, 2'b10, 2'b01, 1'b0, 8'h00, 8'h00};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 8'h41, 8'hA1};

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

    // Reset held with every valid asserted: all outputs stay 0.
    clear_inputs();
    rst = 1'b1;
    req_wr_valid = '1;
    req_rd_valid = '1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check("reset ctrl outputs", {req_wr_ready, req_rd_ready, rsp_rd_valid, ram_wr_en, ram_rd_en,
                                   err_underflow, ram_rd_addr}, 0);
      check("reset data outputs", {rsp_rd_data, ram_wr_addr, ram_wr_data}, 0);
    end
    cyc();
    rst = 1'b0;
    #1;
    check("first write grant", req_wr_ready, 2'b01);

    // Table: write fairness and mixed read/write grants from a fresh reset.
    do_reset();
    set_wr(0, 8'h40, 8'hA0); set_wr(1, 8'h41, 8'hA1);
    set_rd(0, 8'h80);        set_rd(1, 8'h81);
    for (int i = 0; i < 11; i++) begin
      req_wr_valid = tbl[i].wv;
      req_rd_valid = tbl[i].rv;
      #1;
      check($sformatf("tbl[%0d] wr_ready", i), req_wr_ready, tbl[i].wr_rdy);
      check($sformatf("tbl[%0d] rd_ready", i), req_rd_ready, tbl[i].rd_rdy);
      check($sformatf("tbl[%0d] ram_wr_en", i), ram_wr_en, tbl[i].wr_en);
      if (tbl[i].wr_en) begin
        check($sformatf("tbl[%0d] ram_wr_addr", i), ram_wr_addr, tbl[i].wr_addr);
        check($sformatf("tbl[%0d] ram_wr_data", i), ram_wr_data, tbl[i].wr_data);
      end
      cyc();
    end

    // Read routing: client1 then client0, returns in issue order to the right owner.
    do_reset();
    mem[8'h10] = 8'hAA;
    mem[8'h20] = 8'h55;
    set_rd(1, 8'h10);
    req_rd_valid = 2'b10;
    #1;
    check("route rd_ready c1", req_rd_ready, 2'b10);
    cyc();
    set_rd(0, 8'h20);
    req_rd_valid = 2'b01;
    #1;
    check("route rd_ready c0", req_rd_ready, 2'b01);
    cyc();
    req_rd_valid = '0;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      #1;
      if (rsp_rd_valid != '0) begin
        if (got == 0) begin
          check("route rsp1 valid", rsp_rd_valid, 2'b10);
          check("route rsp1 data", rsp_rd_data, 8'hAA);
        end else begin
          check("route rsp2 valid", rsp_rd_valid, 2'b01);
          check("route rsp2 data", rsp_rd_data, 8'h55);
        end
        got++;
      end
      cyc();
    end
    check("route rsp count", got, 2);

    // Backpressure: four reads fill the tag FIFO; a same-cycle return does not free a slot.
    do_reset();
    base = rsp_cnt;
    ret_en = 1'b0;
    set_rd(0, 8'h20);
    req_rd_valid = 2'b01;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("bp rd_ready cyc%0d", c), req_rd_ready, (c < 4) ? 2'b01 : 2'b00);
      cyc();
    end
    ret_one = 1'b1;
    #1;
    check("bp full before return", req_rd_ready, 2'b00);
    cyc();
    ret_one = 1'b0;
    #1;
    check("bp full during pop", req_rd_ready, 2'b00);
    cyc();
    #1;
    check("bp accept after pop", req_rd_ready, 2'b01);
    cyc();
    req_rd_valid = '0;
    ret_en = 1'b1;
    for (int c = 0; c < 30 && (rsp_cnt - base) < 5; c++) cyc();
    check("bp response count", rsp_cnt - base, 5);
    repeat (3) cyc();

    // Underflow: a return with nothing outstanding is dropped and flagged until reset.
    inj = 1'b1;
    #1;
    cyc();
    inj = 1'b0;
    #1;
    check("uf err before", err_underflow, 1'b0);
    cyc();
    #1;
    check("uf no rsp", rsp_rd_valid, 2'b00);
    check("uf err set", err_underflow, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cyc();
      #1;
      check("uf err held", err_underflow, 1'b1);
    end
    do_reset();
    #1;
    check("uf err cleared by reset", err_underflow, 1'b0);
    cyc();

    // Same-address write and read in one cycle.
    mem[8'h33] = 8'h00;
    set_wr(0, 8'h33, 8'h7E);
    set_rd(1, 8'h33);
    req_wr_valid = 2'b01;
    req_rd_valid = 2'b10;
    #1;
    check("coll wr_ready", req_wr_ready, 2'b01);
`ifdef SDP_ARB_COLLISION_STALL_EN
    check("coll rd stalled", req_rd_ready, 2'b00);
    cyc();
    req_wr_valid = '0;
    #1;
    check("coll rd after stall", req_rd_ready, 2'b10);
`else
    check("coll rd same cycle", req_rd_ready, 2'b10);
`endif
    cyc();
    req_wr_valid = '0;
    req_rd_valid = '0;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      #1;
      if (rsp_rd_valid != '0) begin
        check("coll rsp owner", rsp_rd_valid, 2'b10);
`ifdef SDP_ARB_COLLISION_STALL_EN
        check("coll rsp data", rsp_rd_data, 8'h7E);
`endif
        got = 1;
      end
      cyc();
    end
    check("coll rsp seen", got, 1);

    // Randomized traffic against the transaction-level model.
    do_reset();
    for (int i = 0; i < 256; i++) mdl_mem[i] = mem[i];
    wp = 0; rp = 0;
    e_wen = 1'b0; e_ren = 1'b0; e_rsp_v = '0;
    e_waddr = '0; e_wdata = '0; e_raddr = '0; e_rsp_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (i < 375) begin
        req_wr_valid = N'($urandom_range(0, 3));
        req_rd_valid = N'($urandom_range(0, 3));
        ret_en       = ($urandom_range(0, 3) != 0);
      end else begin
        req_wr_valid = '0;
        req_rd_valid = '0;
        ret_en       = 1'b1;
      end
      for (int c = 0; c < N; c++) begin
        set_wr(c, AW'($urandom_range(0, 15)), DW'($urandom));
        set_rd(c, AW'($urandom_range(0, 15)));
      end
      #1;
      ew   = pick(req_wr_valid, wp);
      er   = pick(req_rd_valid, rp);
      coll = 1'b0;
`ifdef SDP_ARB_COLLISION_STALL_EN
      coll = (ew >= 0) && (er >= 0) && (req_wr_addr[ew*AW +: AW] == req_rd_addr[er*AW +: AW]);
`endif
      rd_ok = (er >= 0) && (tq.size() < MAXO) && !coll;
      check("rnd wr_ready", req_wr_ready, (ew >= 0) ? (N'(1) << ew) : '0);
      check("rnd rd_ready", req_rd_ready, rd_ok ? (N'(1) << er) : '0);
      check("rnd ram_wr_en", ram_wr_en, e_wen);
      if (e_wen) check("rnd ram_wr_addr/data", {ram_wr_addr, ram_wr_data}, {e_waddr, e_wdata});
      check("rnd ram_rd_en", ram_rd_en, e_ren);
      if (e_ren) check("rnd ram_rd_addr", ram_rd_addr, e_raddr);
      check("rnd rsp_rd_valid", rsp_rd_valid, e_rsp_v);
      if (e_rsp_v != '0) check("rnd rsp_rd_data", rsp_rd_data, e_rsp_d);
      check("rnd err_underflow", err_underflow, 1'b0);

      popping = ram_rd_data_valid && (tq.size() > 0);
      e_rsp_v = '0;
      if (popping) begin
        hd      = tq.pop_front();
        e_rsp_v = N'(1) << hd.c;
        e_rsp_d = hd.d;
      end
      e_wen = (ew >= 0);
      e_ren = rd_ok;
      if (rd_ok) begin
        e_raddr = req_rd_addr[er*AW +: AW];
        tq.push_back('{er, mdl_mem[e_raddr]});
        rp = (er + 1) % N;
      end
      if (ew >= 0) begin
        e_waddr = req_wr_addr[ew*AW +: AW];
        e_wdata = req_wr_data[ew*DW +: DW];
        mdl_mem[e_waddr] = e_wdata;
        wp = (ew + 1) % N;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
